regfile_wr_arbiter: RTL and testbench

Sequencer and arbiter for the 32×32 register file's single write port. It first runs a post-reset clear sweep that writes zero to every register. It then shares the write port between two writeback requesters: the ALU path (requester 0) and the memory/load path (requester 1). Arbitration is round-robin over a valid/ready handshake. The block sits between the writeback stage and the register file's `we`/`addr3`/`wd` inputs.

---
 rtl/rf_ctrl_pkg.sv | 15 +
 rtl/rr_arb2.sv | 26 ++
 rtl/regfile_wr_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control definitions: FSM state type and register-file geometry.
package rf_ctrl_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant generator; the pointer moves to the loser after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = '0;
    if (en) begin
      if (&valid) grant = ptr ? 2'b10 : 2'b01;
      else        grant = valid;
    end
  end

  // A grant to requester 0 hands priority to requester 1, and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (|grant)  ptr <= grant[0];
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port sequencer: optional post-reset clear sweep, then round-robin
// arbitration between ALU and load writeback. Sweep built only with RF_ARB_INIT_SWEEP_EN.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_W = rf_ctrl_pkg::DATA_W,
  parameter int unsigned ADDR_W = rf_ctrl_pkg::ADDR_W,
  parameter int unsigned NREG   = rf_ctrl_pkg::NREG,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr3,
  output logic [DATA_W-1:0] rf_wd,
  output logic              init_done,
  output logic [CNT_W-1:0]  conflict_cnt
);

  import rf_ctrl_pkg::*;

  if (NREG > (2 ** ADDR_W)) begin : g_bad_nreg
    $error("NREG exceeds the register address space");
  end

  state_t            state;
  logic [1:0]        valid;
  logic [1:0]        grant;
  logic              xfer;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign valid = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == RUN),
    .valid (valid),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign xfer       = |grant;
  assign wr_addr    = grant[1] ? req1_addr : req0_addr;
  assign wr_data    = grant[1] ? req1_data : req0_data;

`ifdef RF_ARB_INIT_SWEEP_EN
  logic [ADDR_W-1:0] sweep_idx;
`endif

  // init_done trails the INIT->RUN transition by one edge in both build variants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      rf_we        <= 1'b0;
      rf_addr3     <= '0;
      rf_wd        <= '0;
      init_done    <= 1'b0;
      conflict_cnt <= '0;
`ifdef RF_ARB_INIT_SWEEP_EN
      sweep_idx    <= '0;
`endif
    end else begin
      case (state)
        INIT: begin
`ifdef RF_ARB_INIT_SWEEP_EN
          rf_we    <= 1'b1;
          rf_addr3 <= sweep_idx;
          rf_wd    <= '0;
          if (sweep_idx == ADDR_W'(NREG - 1)) state <= RUN;
          else                                sweep_idx <= sweep_idx + 1'b1;
`else
          rf_we <= 1'b0;
          state <= RUN;
`endif
        end
        RUN: begin
          init_done <= 1'b1;
          // Register 0 is hard-wired: the transfer is accepted but never written.
          rf_we <= xfer && (wr_addr != ADDR_W'(ZERO_REG));
          if (xfer) begin
            rf_addr3 <= wr_addr;
            rf_wd    <= wr_data;
          end
          if ((&valid) && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [4:0]  rf_addr3;
  logic [31:0] rf_wd;
  logic        init_done;
  logic [15:0] conflict_cnt;

  logic        s_req0_ready, s_req1_ready, s_rf_we, s_init_done;
  logic [4:0]  s_rf_addr3;
  logic [31:0] s_rf_wd;
  logic [1:0]  s_conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_addr3(rf_addr3), .rf_wd(rf_wd),
    .init_done(init_done), .conflict_cnt(conflict_cnt)
  );

  regfile_wr_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(s_req1_ready),
    .rf_we(s_rf_we), .rf_addr3(s_rf_addr3), .rf_wd(s_rf_wd),
    .init_done(s_init_done), .conflict_cnt(s_conflict_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_addr3", 64'(rf_addr3), 64'd0);
    check("rst_rf_wd", 64'(rf_wd), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
    check("rst_sat_cnt", 64'(s_conflict_cnt), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h3333_3333;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h4444_4444;
    #2 rst_n = 1'b0;
    #10;
    check_reset_vals();
    check("rst_ready0", 64'(req0_ready), 64'd0);
    check("rst_ready1", 64'(req1_ready), 64'd0);
    @(negedge clk) rst_n = 1'b1;

`ifdef RF_ARB_INIT_SWEEP_EN
    // Sweep: 32 writes of zero to addresses 0..31, requests held off.
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == 20) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      check("sweep_we", 64'(rf_we), 64'd1);
      check("sweep_addr", 64'(rf_addr3), 64'(i));
      check("sweep_wd", 64'(rf_wd), 64'd0);
      check("sweep_init_done", 64'(init_done), 64'd0);
      #1;
      check("sweep_ready0", 64'(req0_ready), 64'd0);
      check("sweep_ready1", 64'(req1_ready), 64'd0);
    end
    check("sweep_no_conflict", 64'(conflict_cnt), 64'd0);
    tick();
    check("init_done_rise", 64'(init_done), 64'd1);
    check("post_sweep_we", 64'(rf_we), 64'd0);
`else
    #1;
    check("init_ready0", 64'(req0_ready), 64'd0);
    check("init_ready1", 64'(req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("init_we", 64'(rf_we), 64'd0);
    check("init_done_early", 64'(init_done), 64'd0);
    tick();
    check("init_done_rise", 64'(init_done), 64'd1);
    check("post_init_we", 64'(rf_we), 64'd0);
    check("init_no_conflict", 64'(conflict_cnt), 64'd0);
`endif

    // Single req0 write.
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    #1;
    check("r0_ready", 64'(req0_ready), 64'd1);
    check("r0_ready1_idle", 64'(req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0;
    check("r0_we", 64'(rf_we), 64'd1);
    check("r0_addr", 64'(rf_addr3), 64'd5);
    check("r0_wd", 64'(rf_wd), 64'hDEAD_BEEF);
    tick();
    check("r0_we_once", 64'(rf_we), 64'd0);

    // req1 write to register 0: accepted, but no write issued.
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
    #1;
    check("z_ready1", 64'(req1_ready), 64'd1);
    check("z_ready0", 64'(req0_ready), 64'd0);
    tick();
    req1_valid = 1'b0;
    check("z_we", 64'(rf_we), 64'd0);

    // Contention: grants alternate starting with req0.
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1111_0001;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2222_0002;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready0", 64'(req0_ready), 64'((k % 2) == 0));
      check("rr_ready1", 64'(req1_ready), 64'((k % 2) == 1));
      tick();
      check("rr_we", 64'(rf_we), 64'd1);
      check("rr_addr", 64'(rf_addr3), ((k % 2) == 0) ? 64'd1 : 64'd2);
      check("rr_wd", 64'(rf_wd), ((k % 2) == 0) ? 64'h1111_0001 : 64'h2222_0002);
    end
    check("conflict_4", 64'(conflict_cnt), 64'd4);
    check("sat_after_4", 64'(s_conflict_cnt), 64'd3);
    tick();
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("conflict_6", 64'(conflict_cnt), 64'd6);
    check("sat_after_6", 64'(s_conflict_cnt), 64'd3);
    tick();
    check("idle_we", 64'(rf_we), 64'd0);
    check("conflict_hold", 64'(conflict_cnt), 64'd6);

    // Asynchronous reset, then restart.
`ifdef RF_ARB_INIT_SWEEP_EN
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("mid_sweep_addr", 64'(rf_addr3), 64'd9);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("resweep_we", 64'(rf_we), 64'd1);
      check("resweep_addr", 64'(rf_addr3), 64'(i));
      check("resweep_init_done", 64'(init_done), 64'd0);
    end
    tick();
    check("resweep_done", 64'(init_done), 64'd1);
    check("resweep_we_off", 64'(rf_we), 64'd0);
`else
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("reinit_done_early", 64'(init_done), 64'd0);
    check("reinit_we", 64'(rf_we), 64'd0);
    tick();
    check("reinit_done", 64'(init_done), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
